inst_fetch_queue: RTL and testbench

- Parametrised successor to the single-entry-hold instruction fetch stage.
- Owns the fetch PC and issues sequential word-address reads with up to MAX_OUT requests in flight.
- Buffers returned instructions in a DEPTH-entry FIFO feeding decode, and handles branch redirects by flushing the FIFO and discarding stale in-flight responses.
- Sits between the instruction memory bus and the decode stage.

---
 rtl/inst_fetch_queue.sv | 190 +++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch stage with a DEPTH-entry instruction FIFO in front of
// decode. It owns the fetch PC, issues sequential word-address reads with up
// to MAX_OUT requests in flight, and handles branch/exception redirects by
// flushing the FIFO and discarding responses to requests that were issued
// before the redirect.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   defined   - when the FIFO is empty and nothing is being dropped, a memory
//               response is presented to decode in the same cycle it arrives.
//   undefined - every response goes through the FIFO; there is no
//               combinational path from mem_dataQ to out_inst.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low
//   stall          decode not accepting; head entry is held
//   redirect_valid branch/exception redirect
//   redirect_pc    new fetch PC
//   mem_addr       request word address
//   mem_read       request valid
//   mem_gnt        request accepted this cycle (while mem_read=1)
//   mem_ready      response valid (in order, at most one per cycle)
//   mem_dataQ      response data
//   out_valid      head entry valid to decode
//   out_pc         PC of head instruction
//   out_inst       head instruction
//   stop_o         no valid output while a live request is outstanding
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
   parameter int                PC_W     = 30,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter int                MAX_OUT  = 2,
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [PC_W-1:0]   mem_addr,
   output logic              mem_read,
   input  logic              mem_gnt,
   input  logic              mem_ready,
   input  logic [INST_W-1:0] mem_dataQ,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic              stop_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUT) + 1;

   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic [OUT_W-1:0]  drop_q, drop_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic issue_ok;
   logic issue;
   logic acc_resp;
   logic fifo_v;
   logic push;
   logic pop_fifo;

   // Issue decision uses registered counts only: a slot is reserved in the
   // FIFO for every outstanding request, so a response can never overflow.
   assign issue_ok = ((32'(occ_q) + 32'(outst_q)) < 32'(DEPTH)) &&
                     (32'(outst_q) < 32'(MAX_OUT));
   assign mem_read = rst && !redirect_valid && issue_ok;
   assign mem_addr = fetch_pc_q;
   assign issue    = mem_read && mem_gnt;

   // A response is kept only if it is not stale; one arriving in the redirect
   // cycle belongs to the old path and is discarded too.
   assign acc_resp = mem_ready && (drop_q == '0) && !redirect_valid;
   assign fifo_v   = (occ_q != '0);

`ifdef FETCH_BYPASS_EN
   logic byp;

   // Bypass only when the FIFO is empty so program order is preserved.
   assign byp       = acc_resp && !fifo_v;
   assign out_valid = rst && !redirect_valid && (fifo_v || byp);
   assign out_pc    = fifo_v ? pc_mem_q[rd_ptr_q]   : resp_pc_q;
   assign out_inst  = fifo_v ? inst_mem_q[rd_ptr_q] : mem_dataQ;
   assign pop_fifo  = out_valid && !stall && fifo_v;
   // A bypassed response consumed by decode never enters the FIFO.
   assign push      = acc_resp && !(byp && !stall);
`else
   assign out_valid = rst && !redirect_valid && fifo_v;
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_inst  = inst_mem_q[rd_ptr_q];
   assign pop_fifo  = out_valid && !stall;
   assign push      = acc_resp;
`endif

   // outst_q >= drop_q always holds, so inequality means a live request.
   assign stop_o = rst && !out_valid && (outst_q != drop_q);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      occ_d      = occ_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (issue) begin
         fetch_pc_d = fetch_pc_q + PC_W'(1);
         outst_d    = outst_d + OUT_W'(1);
      end
      if (mem_ready) begin
         outst_d = outst_d - OUT_W'(1);
      end
      if (mem_ready && (drop_q != '0)) begin
         drop_d = drop_q - OUT_W'(1);
      end
      if (acc_resp) begin
         resp_pc_d = resp_pc_q + PC_W'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_fifo) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop_fifo})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase

      // Redirect: flush, and mark every request still in flight after this
      // cycle as stale (cumulative with any drops already pending).
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         occ_d      = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         drop_d     = outst_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         occ_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage carries no reset; validity is tracked by occ_q.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= resp_pc_q;
         inst_mem_q[wr_ptr_q] <= mem_dataQ;
      end
   end

   // A response with nothing outstanding is an illegal bus input.
   a_no_spurious_resp: assert property (
      @(posedge clk) disable iff (!rst) mem_ready |-> (outst_q != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

   localparam int PC_W   = 30;
   localparam int INST_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic [PC_W-1:0]   mem_addr;
   logic              mem_read;
   logic              mem_gnt;
   logic              mem_ready;
   logic [INST_W-1:0] mem_dataQ;
   logic              out_valid;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic              stop_o;

   int checks   = 0;
   int failures = 0;

   // Simple memory responder: when enabled, a grant in one cycle is answered
   // with mem_ready in the next cycle.
   bit              auto_mem = 1'b0;
   bit              g_cap;
   logic [PC_W-1:0] a_cap;

   inst_fetch_queue #(
      .PC_W(PC_W), .INST_W(INST_W), .DEPTH(4), .MAX_OUT(2), .RESET_PC('0)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_gnt(mem_gnt),
      .mem_ready(mem_ready), .mem_dataQ(mem_dataQ),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .stop_o(stop_o)
   );

   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] dat(input logic [PC_W-1:0] a);
      return {2'b11, a};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Ends one cycle: capture the grant, cross the clock edge, then update the
   // automatic responder. Returns 1 time unit after the edge.
   task automatic tick;
      #1;
      g_cap = mem_read && mem_gnt;
      a_cap = mem_addr;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         mem_ready = g_cap;
         mem_dataQ = dat(a_cap);
      end
   endtask

   task automatic do_reset;
      auto_mem       = 1'b0;
      rst            = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_gnt        = 1'b0;
      mem_ready      = 1'b0;
      mem_dataQ      = '0;
      tick;
      #2;
      check_eq("rst_mem_read", 64'(mem_read), 64'd0);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_stop", 64'(stop_o), 64'd0);
      tick;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      // ---------------- free-running memory ----------------
      do_reset;
      auto_mem = 1'b1;
      mem_gnt  = 1'b1;
      #2;
      check_eq("t1_c1_read", 64'(mem_read), 64'd1);
      check_eq("t1_c1_addr", 64'(mem_addr), 64'd0);
      check_eq("t1_c1_valid", 64'(out_valid), 64'd0);
      tick;
      #2;
      check_eq("t1_c2_valid", 64'(out_valid), 64'd0);
      check_eq("t1_c2_stop", 64'(stop_o), 64'd1);
      check_eq("t1_c2_addr", 64'(mem_addr), 64'd1);
      tick;
      for (int i = 0; i < 6; i++) begin
         #2;
         check_eq("t1_valid", 64'(out_valid), 64'd1);
         check_eq("t1_pc", 64'(out_pc), 64'(i));
         check_eq("t1_inst", 64'(out_inst), 64'(dat(PC_W'(i))));
         tick;
      end

      // ---------------- stall fills the FIFO ----------------
      do_reset;
      auto_mem = 1'b1;
      mem_gnt  = 1'b1;
      stall    = 1'b1;
      for (int i = 0; i < 5; i++) tick;
      for (int i = 0; i < 5; i++) begin
         #2;
         check_eq("t2_full_read", 64'(mem_read), 64'd0);
         check_eq("t2_hold_valid", 64'(out_valid), 64'd1);
         check_eq("t2_hold_pc", 64'(out_pc), 64'd0);
         tick;
      end
      stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #2;
         check_eq("t2_drain_valid", 64'(out_valid), 64'd1);
         check_eq("t2_drain_pc", 64'(out_pc), 64'(i));
         tick;
      end

      // ---------------- redirect with two in flight ----------------
      do_reset;
      redirect_valid = 1'b1;
      redirect_pc    = PC_W'(5);
      #2;
      check_eq("t3_redir_read", 64'(mem_read), 64'd0);
      tick;
      redirect_valid = 1'b0;
      mem_gnt        = 1'b1;
      #2;
      check_eq("t3_addr5", 64'(mem_addr), 64'd5);
      check_eq("t3_read5", 64'(mem_read), 64'd1);
      tick;
      #2;
      check_eq("t3_addr6", 64'(mem_addr), 64'd6);
      tick;
      redirect_valid = 1'b1;
      redirect_pc    = PC_W'('h100);
      #2;
      check_eq("t3_maxout_read", 64'(mem_read), 64'd0);
      check_eq("t3_stop", 64'(stop_o), 64'd1);
      tick;
      redirect_valid = 1'b0;
      mem_ready      = 1'b1;
      mem_dataQ      = 32'hDEAD0005;
      #2;
      check_eq("t3_drop_stop", 64'(stop_o), 64'd0);
      check_eq("t3_drop_read", 64'(mem_read), 64'd0);
      tick;
      mem_dataQ = 32'hDEAD0006;
      #2;
      check_eq("t3_new_addr", 64'(mem_addr), 64'h100);
      check_eq("t3_new_read", 64'(mem_read), 64'd1);
      check_eq("t3_stale_valid", 64'(out_valid), 64'd0);
      tick;
      mem_dataQ = dat(PC_W'('h100));
      #2;
      check_eq("t3_stale_valid2", 64'(out_valid), 64'd0);
      check_eq("t3_addr101", 64'(mem_addr), 64'h101);
      tick;
      mem_dataQ = dat(PC_W'('h101));
      mem_gnt   = 1'b0;
      #2;
      check_eq("t3_pc100", 64'(out_pc), 64'h100);
      check_eq("t3_inst100", 64'(out_inst), 64'(dat(PC_W'('h100))));
      check_eq("t3_valid100", 64'(out_valid), 64'd1);
      tick;
      mem_ready = 1'b0;
      #2;
      check_eq("t3_pc101", 64'(out_pc), 64'h101);
      tick;
      #2;
      check_eq("t3_empty", 64'(out_valid), 64'd0);

      // ------- redirect with response and push/pop in the same cycle -------
      mem_gnt = 1'b1;
      tick;
      mem_ready = 1'b1;
      mem_dataQ = dat(PC_W'('h102));
      tick;
      mem_dataQ      = dat(PC_W'('h103));
      redirect_valid = 1'b1;
      redirect_pc    = PC_W'('h200);
      #2;
      check_eq("t4_redir_valid", 64'(out_valid), 64'd0);
      check_eq("t4_redir_read", 64'(mem_read), 64'd0);
      tick;
      redirect_valid = 1'b0;
      mem_ready      = 1'b0;
      #2;
      check_eq("t4_flush_valid", 64'(out_valid), 64'd0);
      check_eq("t4_first_read", 64'(mem_read), 64'd1);
      check_eq("t4_first_addr", 64'(mem_addr), 64'h200);
      check_eq("t4_stop", 64'(stop_o), 64'd0);
      tick;
      mem_ready = 1'b1;
      mem_dataQ = dat(PC_W'('h200));
      mem_gnt   = 1'b0;
      #2;
      check_eq("t4_pre_valid", 64'(out_valid), 64'd0);
      tick;
      mem_ready = 1'b0;
      #2;
      check_eq("t4_valid200", 64'(out_valid), 64'd1);
      check_eq("t4_pc200", 64'(out_pc), 64'h200);
      tick;
      #2;
      check_eq("t4_no_dup", 64'(out_valid), 64'd0);

      // ---------------- PC wrap ----------------
      do_reset;
      redirect_valid = 1'b1;
      redirect_pc    = PC_W'('h3FFFFFFF);
      mem_gnt        = 1'b1;
      tick;
      redirect_valid = 1'b0;
      #2;
      check_eq("t5_addr_max", 64'(mem_addr), 64'h3FFFFFFF);
      tick;
      mem_ready = 1'b1;
      mem_dataQ = dat(PC_W'('h3FFFFFFF));
      #2;
      check_eq("t5_wrap_read", 64'(mem_read), 64'd1);
      check_eq("t5_wrap_addr", 64'(mem_addr), 64'd0);
      tick;
      mem_dataQ = dat(PC_W'(0));
      mem_gnt   = 1'b0;
      #2;
      check_eq("t5_pc_max", 64'(out_pc), 64'h3FFFFFFF);
      tick;
      mem_ready = 1'b0;
      #2;
      check_eq("t5_valid0", 64'(out_valid), 64'd1);
      check_eq("t5_pc0", 64'(out_pc), 64'd0);
      tick;
      #2;
      check_eq("t5_empty", 64'(out_valid), 64'd0);

      // ---------------- grant withheld ----------------
      do_reset;
      for (int i = 0; i < 5; i++) begin
         #2;
         check_eq("t6_read_held", 64'(mem_read), 64'd1);
         check_eq("t6_addr_held", 64'(mem_addr), 64'd0);
         check_eq("t6_stop_idle", 64'(stop_o), 64'd0);
         tick;
      end
      mem_gnt = 1'b1;
      #2;
      check_eq("t6_stop_gnt", 64'(stop_o), 64'd0);
      tick;
      mem_gnt = 1'b0;
      #2;
      check_eq("t6_stop_wait", 64'(stop_o), 64'd1);
      check_eq("t6_addr_next", 64'(mem_addr), 64'd1);
      tick;
      mem_ready = 1'b1;
      mem_dataQ = dat(PC_W'(0));
      #2;
      check_eq("t6_stop_resp", 64'(stop_o), 64'd1);
      tick;
      mem_ready = 1'b0;
      #2;
      check_eq("t6_valid", 64'(out_valid), 64'd1);
      check_eq("t6_pc", 64'(out_pc), 64'd0);
      check_eq("t6_stop_done", 64'(stop_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
